elelock_ctrl: RTL and testbench

PIN-entry sequencer for the electronic door lock. Accepts decoded tenkey presses, accumulates a fixed-length BCD code, compares it against the stored code and drives the lock output. Counts failed attempts and enforces a timed lockout with alarm. Sits between the keypad encoder and the lock actuator; the door-closed sensor re-arms it.

---
 rtl/elelock_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_elelock_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elelock_ctrl.sv
// Door-lock PIN sequencer: accumulates a BCD code, compares it against the stored code, and enforces a timed lockout with alarm.
// Latency: enter sampled at edge T, check result on lock/pulses/alarm after edge T+1. No backpressure; unusable keys are dropped.
// Optional: ELELOCK_CODE_CHANGE_EN lets a new code be entered while the door is open.
module elelock_ctrl #(
    parameter int                  DIGITS      = 4,
    parameter logic [4*DIGITS-1:0] CODE        = 16'h1234,
    parameter int                  MAX_FAIL    = 3,
    parameter int                  LOCKOUT_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       close,
    output logic       lock,
    output logic       open_pulse,
    output logic       err_pulse,
    output logic       alarm,
    output logic       code_set
);

    localparam int EW = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int TW = $clog2(LOCKOUT_CYC + 1);

    localparam logic [CW-1:0] CNT_FULL   = CW'(DIGITS);
    localparam logic [FW-1:0] FAIL_LIM   = FW'(MAX_FAIL);
    localparam logic [TW-1:0] TIMER_INIT = TW'(LOCKOUT_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_CHECK,
        S_OPEN,
        S_LOCKOUT
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [EW-1:0] r_entry, w_entry_nxt;
    logic [CW-1:0] r_digit_cnt, w_cnt_nxt;
    logic          r_ovf, w_ovf_nxt;
    logic [FW-1:0] r_fail_cnt, w_fail_nxt;
    logic [TW-1:0] r_timer, w_timer_nxt;
    logic [EW-1:0] r_code, w_code_nxt;
    logic          r_lock, w_lock_nxt;
    logic          r_open_pulse, w_open_nxt;
    logic          r_err_pulse, w_err_nxt;
    logic          r_alarm, w_alarm_nxt;
    logic          r_code_set, w_code_set_nxt;

    logic          w_is_digit;
    logic          w_is_clear;
    logic          w_is_enter;
    logic          w_full;
    logic          w_entry_ok;
    logic [FW-1:0] w_fail_inc;
    logic [EW-1:0] w_entry_shift;

    assign w_is_digit    = key_valid && (key_code <= 4'd9);
    assign w_is_clear    = key_valid && (key_code == 4'hA);
    assign w_is_enter    = key_valid && (key_code == 4'hB);
    assign w_full        = (r_digit_cnt == CNT_FULL);
    assign w_entry_ok    = w_full && !r_ovf;
    assign w_fail_inc    = r_fail_cnt + FW'(1);
    assign w_entry_shift = (r_entry << 4) | EW'(key_code);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_entry      <= '0;
            r_digit_cnt  <= '0;
            r_ovf        <= 1'b0;
            r_fail_cnt   <= '0;
            r_timer      <= '0;
            r_code       <= CODE;
            r_lock       <= 1'b1;
            r_open_pulse <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_alarm      <= 1'b0;
            r_code_set   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_entry      <= w_entry_nxt;
            r_digit_cnt  <= w_cnt_nxt;
            r_ovf        <= w_ovf_nxt;
            r_fail_cnt   <= w_fail_nxt;
            r_timer      <= w_timer_nxt;
            r_code       <= w_code_nxt;
            r_lock       <= w_lock_nxt;
            r_open_pulse <= w_open_nxt;
            r_err_pulse  <= w_err_nxt;
            r_alarm      <= w_alarm_nxt;
            r_code_set   <= w_code_set_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_entry_nxt    = r_entry;
        w_cnt_nxt      = r_digit_cnt;
        w_ovf_nxt      = r_ovf;
        w_fail_nxt     = r_fail_cnt;
        w_timer_nxt    = r_timer;
        w_code_nxt     = r_code;
        w_lock_nxt     = r_lock;
        w_open_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_alarm_nxt    = r_alarm;
        w_code_set_nxt = 1'b0;

        case (r_state)
            S_IDLE, S_ENTRY: begin
                w_lock_nxt = 1'b1;
                if (w_is_digit) begin
                    w_state_nxt = S_ENTRY;
                    // Extra digits poison the attempt instead of scrolling the code.
                    if (w_full) begin
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_entry_nxt = w_entry_shift;
                        w_cnt_nxt   = r_digit_cnt + CW'(1);
                    end
                end else if (w_is_clear) begin
                    w_state_nxt = S_IDLE;
                    w_entry_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_ovf_nxt   = 1'b0;
                end else if (w_is_enter) begin
                    w_state_nxt = S_CHECK;
                end
            end

            S_CHECK: begin
                w_entry_nxt = '0;
                w_cnt_nxt   = '0;
                w_ovf_nxt   = 1'b0;
                if (w_entry_ok && (r_entry == r_code)) begin
                    w_state_nxt = S_OPEN;
                    w_lock_nxt  = 1'b0;
                    w_open_nxt  = 1'b1;
                    w_fail_nxt  = '0;
                end else begin
                    w_err_nxt  = 1'b1;
                    w_fail_nxt = w_fail_inc;
                    if (w_fail_inc == FAIL_LIM) begin
                        w_state_nxt = S_LOCKOUT;
                        w_alarm_nxt = 1'b1;
                        w_timer_nxt = TIMER_INIT;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            S_OPEN: begin
                w_lock_nxt = 1'b0;
                if (close) begin
                    w_state_nxt = S_IDLE;
                    w_lock_nxt  = 1'b1;
                    w_entry_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_ovf_nxt   = 1'b0;
                end
`ifdef ELELOCK_CODE_CHANGE_EN
                else if (w_is_digit) begin
                    if (w_full) begin
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_entry_nxt = w_entry_shift;
                        w_cnt_nxt   = r_digit_cnt + CW'(1);
                    end
                end else if (w_is_clear || w_is_enter) begin
                    if (w_is_enter && w_entry_ok) begin
                        w_code_nxt     = r_entry;
                        w_code_set_nxt = 1'b1;
                    end
                    w_entry_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_ovf_nxt   = 1'b0;
                end
`endif
            end

            S_LOCKOUT: begin
                w_lock_nxt = 1'b1;
                if (r_timer == TW'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_alarm_nxt = 1'b0;
                    w_fail_nxt  = '0;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign lock       = r_lock;
    assign open_pulse = r_open_pulse;
    assign err_pulse  = r_err_pulse;
    assign alarm      = r_alarm;
    assign code_set   = r_code_set;

endmodule

// File: tb/tb_elelock_ctrl.sv
// Bench for elelock_ctrl: directed test-plan steps plus random key traffic against a digit-queue reference model.
module tb_elelock_ctrl;

    localparam int          DIGITS      = 4;
    localparam logic [15:0] CODE        = 16'h1234;
    localparam int          MAX_FAIL    = 3;
    localparam int          LOCKOUT_CYC = 16;
`ifdef ELELOCK_CODE_CHANGE_EN
    localparam bit CHG_EN = 1'b1;
`else
    localparam bit CHG_EN = 1'b0;
`endif

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code  = 4'h0;
    logic       close     = 1'b0;
    logic       lock, open_pulse, err_pulse, alarm, code_set;

    elelock_ctrl #(
        .DIGITS      (DIGITS),
        .CODE        (CODE),
        .MAX_FAIL    (MAX_FAIL),
        .LOCKOUT_CYC (LOCKOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .close      (close),
        .lock       (lock),
        .open_pulse (open_pulse),
        .err_pulse  (err_pulse),
        .alarm      (alarm),
        .code_set   (code_set)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: typed digits as a queue, stored code as a queue,
    // lockout as a remaining-cycle count.
    int m_dig[$];
    int m_code[$];
    bit m_ovf, m_pend, m_open;
    int m_left, m_fails;
    bit e_lock, e_open, e_err, e_alarm, e_cs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_dig.delete();
        m_code.delete();
        for (int i = 0; i < DIGITS; i++)
            m_code.push_back(int'((CODE >> (4 * (DIGITS - 1 - i))) & 16'hF));
        m_ovf = 0; m_pend = 0; m_open = 0; m_left = 0; m_fails = 0;
        e_lock = 1; e_open = 0; e_err = 0; e_alarm = 0; e_cs = 0;
    endtask

    task automatic m_clear();
        m_dig.delete();
        m_ovf = 0;
    endtask

    task automatic m_digit(input int d);
        if (m_dig.size() < DIGITS) m_dig.push_back(d);
        else m_ovf = 1;
    endtask

    function automatic bit m_match();
        if (m_ovf || m_dig.size() != DIGITS) return 0;
        for (int i = 0; i < DIGITS; i++)
            if (m_dig[i] != m_code[i]) return 0;
        return 1;
    endfunction

    task automatic model_step(input bit kv, input int kc, input bit cl);
        e_open = 0; e_err = 0; e_cs = 0;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                e_alarm = 0;
                m_fails = 0;
            end
        end else if (m_pend) begin
            m_pend = 0;
            if (m_match()) begin
                m_open = 1; e_lock = 0; e_open = 1; m_fails = 0;
            end else begin
                e_err = 1;
                m_fails++;
                if (m_fails == MAX_FAIL) begin
                    m_left  = LOCKOUT_CYC;
                    e_alarm = 1;
                end
            end
            m_clear();
        end else if (m_open) begin
            if (cl) begin
                m_open = 0; e_lock = 1;
                m_clear();
            end else if (kv && CHG_EN) begin
                if (kc <= 9) m_digit(kc);
                else if (kc == 10) m_clear();
                else if (kc == 11) begin
                    if (m_dig.size() == DIGITS && !m_ovf) begin
                        m_code = m_dig;
                        e_cs   = 1;
                    end
                    m_clear();
                end
            end
        end else if (kv) begin
            if (kc <= 9) m_digit(kc);
            else if (kc == 10) m_clear();
            else if (kc == 11) m_pend = 1;
        end
    endtask

    task automatic tick(input bit kv, input logic [3:0] kc, input bit cl);
        key_valid = kv;
        key_code  = kc;
        close     = cl;
        @(posedge clk);
        model_step(kv, int'(kc), cl);
        #1;
        chk("lock", lock, e_lock);
        chk("open_pulse", open_pulse, e_open);
        chk("err_pulse", err_pulse, e_err);
        chk("alarm", alarm, e_alarm);
        chk("code_set", code_set, e_cs);
        chk("pulse_excl", open_pulse & err_pulse, 1'b0);
        key_valid = 1'b0;
        close     = 1'b0;
    endtask

    task automatic press_seq(input logic [31:0] seq, input int n);
        logic [31:0] s;
        s = seq;
        for (int i = 0; i < n; i++) tick(1'b1, s[4 * (n - 1 - i) +: 4], 1'b0);
    endtask

    task automatic wrong_thrice();
        for (int i = 0; i < MAX_FAIL - 1; i++) begin
            press_seq(32'h9999B, 5);
            tick(1'b0, 4'h0, 1'b0);
        end
        press_seq(32'h9999B, 5);
    endtask

    int          acnt;
    int          r;
    logic [19:0] ks;

    initial begin
        model_reset();
        #2 rst_n = 1'b0;
        #10;
        chk("rst_lock", lock, 1'b1);
        chk("rst_open", open_pulse, 1'b0);
        chk("rst_err", err_pulse, 1'b0);
        chk("rst_alarm", alarm, 1'b0);
        chk("rst_code_set", code_set, 1'b0);
        #1 rst_n = 1'b1;

        // correct code: lock drops on the second edge after '#'
        press_seq(32'h1234B, 5);
        chk("pre_open_lock", lock, 1'b1);
        tick(1'b0, 4'h0, 1'b0);
        chk("open_lock", lock, 1'b0);
        chk("open_pulse_hi", open_pulse, 1'b1);
        tick(1'b0, 4'h0, 1'b0);
        chk("open_pulse_one", open_pulse, 1'b0);
        tick(1'b0, 4'h0, 1'b1);
        chk("close_lock", lock, 1'b1);

        // wrong code then right code
        press_seq(32'h1235B, 5);
        tick(1'b0, 4'h0, 1'b0);
        chk("wrong_err", err_pulse, 1'b1);
        chk("wrong_lock", lock, 1'b1);
        tick(1'b0, 4'h0, 1'b0);
        chk("err_one", err_pulse, 1'b0);
        press_seq(32'h1234B, 5);
        tick(1'b0, 4'h0, 1'b0);
        chk("retry_open", open_pulse, 1'b1);
        tick(1'b0, 4'h0, 1'b1);

        // lockout length, keys ignored throughout
        wrong_thrice();
        acnt = 0;
        ks   = 20'h1234B;
        for (int i = 0; i < 40; i++) begin
            if (i >= 1 && i <= 5) tick(1'b1, ks[4 * (5 - i) +: 4], 1'b0);
            else tick(1'b0, 4'h0, 1'b0);
            if (alarm === 1'b1) acnt++;
            else break;
        end
        chk("alarm_len", acnt, LOCKOUT_CYC);
        chk("post_lockout_lock", lock, 1'b1);
        press_seq(32'h1234B, 5);
        tick(1'b0, 4'h0, 1'b0);
        chk("post_lockout_open", open_pulse, 1'b1);
        tick(1'b0, 4'h0, 1'b1);

        // overflow, clear mid-entry, bare enter
        press_seq(32'h12345B, 6);
        tick(1'b0, 4'h0, 1'b0);
        chk("ovf_err", err_pulse, 1'b1);
        press_seq(32'h12A1234B, 8);
        tick(1'b0, 4'h0, 1'b0);
        chk("clear_open", open_pulse, 1'b1);
        tick(1'b0, 4'h0, 1'b1);
        press_seq(32'hB, 1);
        tick(1'b0, 4'h0, 1'b0);
        chk("empty_err", err_pulse, 1'b1);

        // close wins over a simultaneous key
        press_seq(32'h1234B, 5);
        tick(1'b0, 4'h0, 1'b0);
        tick(1'b1, 4'h5, 1'b1);
        chk("close_key_lock", lock, 1'b1);
        press_seq(32'h1234B, 5);
        tick(1'b0, 4'h0, 1'b0);
        chk("key_dropped_open", open_pulse, 1'b1);
        tick(1'b0, 4'h0, 1'b1);

        // reset during lockout acts immediately
        wrong_thrice();
        tick(1'b0, 4'h0, 1'b0);
        tick(1'b0, 4'h0, 1'b0);
        tick(1'b0, 4'h0, 1'b0);
        chk("lockout_alarm", alarm, 1'b1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_alarm", alarm, 1'b0);
        chk("arst_lock", lock, 1'b1);
        #2 rst_n = 1'b1;

        // code change while open
        press_seq(32'h1234B, 5);
        tick(1'b0, 4'h0, 1'b0);
        press_seq(32'h5678B, 5);
        chk("code_set_pulse", code_set, CHG_EN);
        tick(1'b0, 4'h0, 1'b0);
        chk("code_set_one", code_set, 1'b0);
        tick(1'b0, 4'h0, 1'b1);
        press_seq(32'h1234B, 5);
        tick(1'b0, 4'h0, 1'b0);
        chk("old_code_open", open_pulse, !CHG_EN);
        chk("old_code_err", err_pulse, CHG_EN);
        tick(1'b0, 4'h0, 1'b1);
        press_seq(32'h5678B, 5);
        tick(1'b0, 4'h0, 1'b0);
        chk("new_code_open", open_pulse, CHG_EN);
        chk("new_code_err", err_pulse, !CHG_EN);
        tick(1'b0, 4'h0, 1'b1);

        // random traffic against the model
        for (int it = 0; it < 600; it++) begin
            r = $urandom_range(0, 99);
            if (r < 25) begin
                for (int j = 0; j < m_code.size(); j++) tick(1'b1, 4'(m_code[j]), 1'b0);
                tick(1'b1, 4'hB, 1'b0);
                tick(1'b0, 4'h0, 1'b0);
            end else begin
                tick($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 7) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
